peripheral_slave_mem_wb: RTL and testbench

Synthesizable, parametrised Wishbone B3 slave memory for the GPIO bench and SoC integration tests. It replaces scripted per-transfer slave responses with a self-contained word RAM that supports:
- configurable wait states;
- registered-feedback bursts (constant, incrementing, wrap-4/8/16);
- byte-lane writes;
- an address error window.

It sits on the same Wishbone interconnect as the GPIO core, driven by the existing master BFM.

---
 rtl/peripheral_slave_mem_wb.sv | 175 +++++++++++++++++
 tb/tb_peripheral_slave_mem_wb.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/peripheral_slave_mem_wb.sv
// Wishbone B3 slave word RAM with wait states, registered-feedback bursts,
// byte-lane writes and an address error window.
module peripheral_slave_mem_wb #(
   parameter int DW          = 32,
   parameter int AW          = 32,
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 0,
   parameter int ERR_BASE    = 0,
   parameter int ERR_SIZE    = 0
) (
   input  logic            wb_clk,
   input  logic            wb_rst,
   input  logic [AW-1:0]   wb_adr_i,
   input  logic [DW-1:0]   wb_dat_i,
   input  logic [DW/8-1:0] wb_sel_i,
   input  logic            wb_we_i,
   input  logic            wb_cyc_i,
   input  logic            wb_stb_i,
   input  logic [2:0]      wb_cti_i,
   input  logic [1:0]      wb_bte_i,
   output logic [DW-1:0]   wb_dat_o,
   output logic            wb_ack_o,
   output logic            wb_err_o,
   output logic            wb_rty_o
);

   localparam int SW = DW / 8;
   localparam int LB = (SW > 1) ? $clog2(SW) : 0;
   localparam int IW = AW - LB;
   localparam int MW = $clog2(DEPTH);
   localparam logic [IW:0] DEP_L = (IW+1)'(DEPTH);
   localparam logic [3:0]  WS_L  = 4'(WAIT_STATES);

   typedef enum logic [1:0] {IDLE, WAIT, ACK, BURST} state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          we_q, we_d;
   logic [2:0]    cti_q, cti_d;
   logic [1:0]    bte_q, bte_d;
   logic [3:0]    cnt_q, cnt_d;

   logic [DW-1:0] mem_q [DEPTH];

   logic [IW:0]   idx_x;
   logic          in_win;
   logic          legal;
   logic          beat;
   logic          wr_en;
   logic          cont;
   logic [2:0]    cti_cur;
   logic [IW-1:0] wmask;
   logic [IW-1:0] idx_inc;
   logic [IW-1:0] idx_nxt;

   assign idx_x = {1'b0, idx_q};

   if (ERR_SIZE > 0) begin : g_win
      localparam logic [IW:0] EB_L = (IW+1)'(ERR_BASE);
      localparam logic [IW:0] SZ_L = (IW+1)'(ERR_SIZE);
      // unsigned wrap makes indices below the base look huge
      assign in_win = (idx_x - EB_L) < SZ_L;
   end else begin : g_nowin
      assign in_win = 1'b0;
   end

   if (LB > 0) begin : g_lo
      logic unused_lo;
      assign unused_lo = ^wb_adr_i[LB-1:0];
   end

   assign legal   = (idx_x < DEP_L) && !in_win;
   assign beat    = wb_cyc_i &&
                    ((state_q == ACK) || (state_q == BURST && wb_stb_i));
   assign wr_en   = beat && legal && we_q;
   assign cti_cur = (state_q == BURST) ? wb_cti_i : cti_q;
   assign cont    = (cti_cur == 3'b001) || (cti_cur == 3'b010);
   assign idx_inc = idx_q + IW'(1);

   always_comb begin
      wmask = '1;
      unique case (bte_q)
         2'b01:   wmask = IW'(3);
         2'b10:   wmask = IW'(7);
         2'b11:   wmask = IW'(15);
         default: wmask = '1;
      endcase
   end

   assign idx_nxt = (cti_cur == 3'b001) ? idx_q
                  : ((idx_q & ~wmask) | (idx_inc & wmask));

   assign wb_ack_o = beat && legal;
   assign wb_err_o = beat && !legal;
   assign wb_rty_o = 1'b0;
   assign wb_dat_o = wb_ack_o ? mem_q[idx_q[MW-1:0]] : '0;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      we_d    = we_q;
      cti_d   = cti_q;
      bte_d   = bte_q;
      cnt_d   = cnt_q;
      if (!wb_cyc_i) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: if (wb_stb_i) begin
               idx_d = wb_adr_i[AW-1:LB];
               we_d  = wb_we_i;
               cti_d = wb_cti_i;
               bte_d = wb_bte_i;
               if (WAIT_STATES > 0) begin
                  state_d = WAIT;
                  cnt_d   = WS_L;
               end else begin
                  state_d = ACK;
               end
            end
            WAIT: begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q <= 4'd1) begin
                  state_d = ACK;
                  cnt_d   = '0;
                  cti_d   = wb_cti_i;
               end
            end
            ACK, BURST: if (beat) begin
               if (!legal || !cont) begin
                  state_d = IDLE;
               end else begin
                  idx_d = idx_nxt;
                  if (WAIT_STATES > 0) begin
                     state_d = WAIT;
                     cnt_d   = WS_L;
                  end else begin
                     state_d = BURST;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge wb_clk or negedge wb_rst) begin
      if (!wb_rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         we_q    <= 1'b0;
         cti_q   <= '0;
         bte_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         we_q    <= we_d;
         cti_q   <= cti_d;
         bte_q   <= bte_d;
         cnt_q   <= cnt_d;
      end
   end

   // contents survive reset; state reset alone blocks in-flight writes
   always_ff @(posedge wb_clk) begin
      if (wr_en) begin
         for (int b = 0; b < SW; b++) begin
            if (wb_sel_i[b]) mem_q[idx_q[MW-1:0]][8*b +: 8] <= wb_dat_i[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_peripheral_slave_mem_wb.sv
// Bench for peripheral_slave_mem_wb: u0 has no wait states and an error
// window at words 0x20..0x23, u1 has three wait states.
module tb_peripheral_slave_mem_wb;

   localparam int NC = 2048;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] adr, dwr;
   logic [3:0]  sel;
   logic        we, stb;
   logic [1:0]  cyc;
   logic [2:0]  cti;
   logic [1:0]  bte;
   logic [31:0] dat0, dat1;
   logic        ack0, err0, rty0, ack1, err1, rty1;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc_n   = 0;

   bit          exp_ack [2][NC];
   bit          exp_err [2][NC];
   bit          chk_dat [2][NC];
   logic [31:0] exp_dat [2][NC];
   logic [31:0] mem_m   [2][256];

   logic [31:0] brd  [16];
   logic [1:0]  brsp [16];

   always #5 clk = ~clk;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   peripheral_slave_mem_wb #(
      .WAIT_STATES(0), .ERR_BASE(32), .ERR_SIZE(4)
   ) u0 (
      .wb_clk(clk), .wb_rst(rst_n), .wb_adr_i(adr), .wb_dat_i(dwr),
      .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc[0]), .wb_stb_i(stb),
      .wb_cti_i(cti), .wb_bte_i(bte), .wb_dat_o(dat0), .wb_ack_o(ack0),
      .wb_err_o(err0), .wb_rty_o(rty0)
   );

   peripheral_slave_mem_wb #(
      .WAIT_STATES(3)
   ) u1 (
      .wb_clk(clk), .wb_rst(rst_n), .wb_adr_i(adr), .wb_dat_i(dwr),
      .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc[1]), .wb_stb_i(stb),
      .wb_cti_i(cti), .wb_bte_i(bte), .wb_dat_o(dat1), .wb_ack_o(ack1),
      .wb_err_o(err1), .wb_rty_o(rty1)
   );

   function automatic bit legal(input int d, input int idx);
      if (idx >= 256) return 1'b0;
      if (d == 0 && idx >= 32 && idx < 36) return 1'b0;
      return 1'b1;
   endfunction

   function automatic int nxt(input int idx, input int l);
      if (l == 0) return idx + 1;
      return idx - (idx % l) + ((idx + 1) % l);
   endfunction

   // schedule the response of one beat at cycle t and apply its write
   function automatic bit plan(input int d, input int t, input int idx,
                               input bit w, input logic [3:0] s,
                               input logic [31:0] wd);
      if (!legal(d, idx)) begin
         exp_err[d][t] = 1'b1;
         return 1'b0;
      end
      exp_ack[d][t] = 1'b1;
      if (!w) begin
         chk_dat[d][t] = 1'b1;
         exp_dat[d][t] = mem_m[d][idx];
      end else begin
         for (int b = 0; b < 4; b++)
            if (s[b]) mem_m[d][idx][8*b +: 8] = wd[8*b +: 8];
      end
      return 1'b1;
   endfunction

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] want);
      n_tests++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", name, act, want);
      end
   endtask

   task automatic cmp(input int d, input logic a, input logic e,
                      input logic r, input logic [31:0] dt);
      bit ok;
      bit ea, ee;
      ea = exp_ack[d][cyc_n];
      ee = exp_err[d][cyc_n];
      ok = (a === ea) && (e === ee) && (r === 1'b0);
      if (ea) begin
         if (chk_dat[d][cyc_n] && dt !== exp_dat[d][cyc_n]) ok = 1'b0;
      end else if (dt !== 32'h0) begin
         ok = 1'b0;
      end
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL cmp_u%0d cyc %0d: ack=%b err=%b rty=%b dat=%h want ack=%b err=%b dat=%h",
                  d, cyc_n, a, e, r, dt, ea, ee, exp_dat[d][cyc_n]);
      end
   endtask

   always @(negedge clk) begin
      if (cyc_n < NC) begin
         cmp(0, ack0, err0, rty0, dat0);
         cmp(1, ack1, err1, rty1, dat1);
      end
   end

   task automatic idle_bus();
      cyc = '0; stb = 1'b0; we = 1'b0; cti = 3'b000; bte = 2'b00;
   endtask

   // called at posedge+1; returns at posedge+1 with the bus idle
   task automatic classic(input int d, input bit w, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] s,
                          output logic [31:0] rd, output logic [1:0] rsp);
      int ws;
      int c;
      ws = (d == 1) ? 3 : 0;
      c  = cyc_n;
      adr = a; dwr = wd; sel = s; we = w; stb = 1'b1;
      cti = 3'b000; bte = 2'b00;
      cyc[d] = 1'b1;
      void'(plan(d, c + 1 + ws, int'(a >> 2), w, s, wd));
      repeat (1 + ws) @(posedge clk);
      @(negedge clk);
      rd  = d ? dat1 : dat0;
      rsp = d ? {err1, ack1} : {err0, ack0};
      @(posedge clk);
      #1;
      idle_bus();
   endtask

   task automatic burst(input bit w, input int i0, input int l, input int n);
      int c;
      int idx;
      bit ok;
      c   = cyc_n;
      idx = i0;
      adr = 32'(i0) << 2; we = w; sel = 4'hF; stb = 1'b1;
      dwr = 32'hB000_0000;
      cti = (n == 1) ? 3'b111 : 3'b010;
      bte = (l == 4) ? 2'b01 : (l == 8) ? 2'b10 : (l == 16) ? 2'b11 : 2'b00;
      cyc[0] = 1'b1;
      for (int i = 0; i < n; i++) begin
         ok  = plan(0, c + 1 + i, idx, w, 4'hF, 32'hB000_0000 + 32'(i));
         idx = nxt(idx, l);
         @(posedge clk);
         #1;
         if (i > 0) begin
            cti = (i == n - 1) ? 3'b111 : 3'b010;
            dwr = 32'hB000_0000 + 32'(i);
         end
         @(negedge clk);
         brd[i]  = dat0;
         brsp[i] = {err0, ack0};
         if (!ok) break;
      end
      @(posedge clk);
      #1;
      idle_bus();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic [1:0]  rsp;
      int          c;

      rst_n = 1'b0;
      adr = '0; dwr = '0; sel = '0;
      idle_bus();
      repeat (3) @(posedge clk);
      #1;
      check("rst_flags", {26'b0, ack0, err0, rty0, ack1, err1, rty1}, 32'h0);
      check("rst_dat", dat0 | dat1, 32'h0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      classic(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, rd, rsp);
      check("classic_wr_rsp", {30'b0, rsp}, 32'h1);
      classic(0, 1'b0, 32'h10, 32'h0, 4'hF, rd, rsp);
      check("classic_rd_rsp", {30'b0, rsp}, 32'h1);
      check("classic_rd_dat", rd, 32'hDEAD_BEEF);

      classic(0, 1'b1, 32'h40, 32'hAABB_CCDD, 4'hF, rd, rsp);
      classic(0, 1'b1, 32'h40, 32'h1122_3344, 4'b0101, rd, rsp);
      classic(0, 1'b0, 32'h40, 32'h0, 4'hF, rd, rsp);
      check("byte_lane_dat", rd, 32'hAA22_CC44);

      for (int i = 4; i < 8; i++)
         classic(0, 1'b1, 32'(i) << 2, 32'(i), 4'hF, rd, rsp);
      burst(1'b0, 6, 4, 4);
      check("wrap4_b0", brd[0], 32'd6);
      check("wrap4_b1", brd[1], 32'd7);
      check("wrap4_b2", brd[2], 32'd4);
      check("wrap4_b3", brd[3], 32'd5);
      check("wrap4_rsp", {24'b0, brsp[0], brsp[1], brsp[2], brsp[3]}, 32'h55);

      classic(0, 1'b1, 32'h0, 32'hC0FF_EE00, 4'hF, rd, rsp);
      burst(1'b1, 254, 0, 3);
      check("lin_rsp", {26'b0, brsp[0], brsp[1], brsp[2]}, 32'h16);
      classic(0, 1'b0, 32'(254) << 2, 32'h0, 4'hF, rd, rsp);
      check("lin_w254", rd, 32'hB000_0000);
      classic(0, 1'b0, 32'(255) << 2, 32'h0, 4'hF, rd, rsp);
      check("lin_w255", rd, 32'hB000_0001);
      classic(0, 1'b0, 32'h0, 32'h0, 4'hF, rd, rsp);
      check("lin_no_alias", rd, 32'hC0FF_EE00);
      classic(0, 1'b0, 32'h400, 32'h0, 4'hF, rd, rsp);
      check("oob_rsp", {30'b0, rsp}, 32'h2);

      classic(0, 1'b1, 32'h84, 32'h5555_AAAA, 4'hF, rd, rsp);
      check("win_wr_rsp", {30'b0, rsp}, 32'h2);
      classic(0, 1'b0, 32'h84, 32'h0, 4'hF, rd, rsp);
      check("win_rd_rsp", {30'b0, rsp}, 32'h2);
      check("win_rd_dat", rd, 32'h0);
      classic(0, 1'b1, 32'h90, 32'h0BAD_F00D, 4'hF, rd, rsp);
      classic(0, 1'b0, 32'h90, 32'h0, 4'hF, rd, rsp);
      check("win_edge_dat", rd, 32'h0BAD_F00D);
      classic(0, 1'b1, 32'h7C, 32'h1357_9BDF, 4'hF, rd, rsp);
      check("win_below_rsp", {30'b0, rsp}, 32'h1);

      classic(1, 1'b1, 32'h20, 32'h1234_5678, 4'hF, rd, rsp);
      classic(1, 1'b0, 32'h20, 32'h0, 4'hF, rd, rsp);
      check("ws3_rd_rsp", {30'b0, rsp}, 32'h1);
      check("ws3_rd_dat", rd, 32'h1234_5678);

      adr = 32'h20; dwr = 32'h0000_0BAD; sel = 4'hF; we = 1'b1;
      stb = 1'b1; cyc[1] = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      idle_bus();
      repeat (4) @(posedge clk);
      #1;
      classic(1, 1'b0, 32'h20, 32'h0, 4'hF, rd, rsp);
      check("drop_cyc_dat", rd, 32'h1234_5678);

      c = cyc_n;
      adr = 32'h20; dwr = 32'hFEED_FACE; sel = 4'hF; we = 1'b1;
      stb = 1'b1; cyc[1] = 1'b1;
      exp_ack[1][c + 4] = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("pre_rst_ack", {31'b0, ack1}, 32'h1);
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_async_flags", {29'b0, ack1, err1, rty1}, 32'h0);
      check("rst_async_dat", dat1, 32'h0);
      idle_bus();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      classic(1, 1'b0, 32'h20, 32'h0, 4'hF, rd, rsp);
      check("rst_no_commit", rd, 32'h1234_5678);
      classic(0, 1'b0, 32'h40, 32'h0, 4'hF, rd, rsp);
      check("mem_kept_rst", rd, 32'hAA22_CC44);

      repeat (2) @(posedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
